// File: rtl/la_capture_core.sv
// la_capture_core: logic-analyzer capture engine.
// Circular sample RAM, pre-trigger window, aligned readout.
module la_capture_core #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 9
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] probe_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [1:0]        trig_mode_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_value_i,
  input  logic [ADDR_W:0]   pretrig_i,
  output logic [1:0]        state_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_addr_o,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [ADDR_W:0] LAST_W = {1'b0, LAST};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state;

  logic [DATA_W-1:0] ram [DEPTH];

  logic [1:0]        mode_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] value_q;
  logic [ADDR_W-1:0] pt_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic              match_d;

  logic              match;
  logic              trig;
  logic              writing;
  logic [ADDR_W-1:0] pt_new;
  logic [ADDR_W-1:0] post_init;
  logic [ADDR_W-1:0] rd_phys;

  // DONE shares encoding 0 on state_o; done_o tells it apart
  assign state_o = state[1:0];

  assign match = ((probe_i ^ value_q) & mask_q) == '0;

  assign pt_new = (pretrig_i > LAST_W)
                ? LAST
                : pretrig_i[ADDR_W-1:0];

  assign post_init = LAST - pt_q;

  assign rd_phys = trig_addr_o - pt_q + rd_addr_i;

  assign writing = (state == S_PRE)
                || (state == S_WAIT)
                || (state == S_POST);

  always_comb begin
    trig = 1'b0;
    unique case (1'b1)
      (mode_q == 2'b00): trig = match;
      (mode_q == 2'b01): trig = match & ~match_d;
      (mode_q == 2'b10): trig = ~match & match_d;
      (mode_q == 2'b11): trig = 1'b1;
      default:           trig = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (writing) begin
      ram[wr_ptr] <= probe_i;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      triggered_o <= 1'b0;
      done_o      <= 1'b0;
      trig_addr_o <= '0;
      mode_q      <= '0;
      mask_q      <= '0;
      value_q     <= '0;
      pt_q        <= '0;
      wr_ptr      <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      match_d     <= 1'b0;
    end else begin
      match_d <= match;
      if (abort_i) begin
        state  <= S_IDLE;
        done_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (arm_i) begin
              mode_q      <= trig_mode_i;
              mask_q      <= trig_mask_i;
              value_q     <= trig_value_i;
              pt_q        <= pt_new;
              wr_ptr      <= '0;
              pre_cnt     <= '0;
              triggered_o <= 1'b0;
              done_o      <= 1'b0;
              state <= (pt_new == '0) ? S_WAIT : S_PRE;
            end
          end
          S_PRE: begin
            wr_ptr  <= wr_ptr + 1'b1;
            pre_cnt <= pre_cnt + 1'b1;
            if (pre_cnt == pt_q - 1'b1) begin
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            wr_ptr <= wr_ptr + 1'b1;
            if (trig) begin
              trig_addr_o <= wr_ptr;
              triggered_o <= 1'b1;
              post_cnt    <= post_init;
              if (post_init == '0) begin
                state  <= S_DONE;
                done_o <= 1'b1;
              end else begin
                state <= S_POST;
              end
            end
          end
          S_POST: begin
            wr_ptr   <= wr_ptr + 1'b1;
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == ADDR_W'(1)) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_en_i && (state == S_DONE);
      if (rd_en_i && (state == S_DONE)) begin
        rd_data_o <= ram[rd_phys];
      end
    end
  end

endmodule

// File: tb/tb_la_capture_core.sv
// tb_la_capture_core: scoreboard bench for la_capture_core.
// Model derives trigger index, timing and RAM contents.
module tb_la_capture_core;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] probe_i;
  logic          arm_i;
  logic          abort_i;
  logic [1:0]    trig_mode_i;
  logic [DW-1:0] trig_mask_i;
  logic [DW-1:0] trig_value_i;
  logic [AW:0]   pretrig_i;
  logic [1:0]    state_o;
  logic          triggered_o;
  logic          done_o;
  logic [AW-1:0] trig_addr_o;
  logic          rd_en_i;
  logic [AW-1:0] rd_addr_i;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;

  la_capture_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .probe_i      (probe_i),
    .arm_i        (arm_i),
    .abort_i      (abort_i),
    .trig_mode_i  (trig_mode_i),
    .trig_mask_i  (trig_mask_i),
    .trig_value_i (trig_value_i),
    .pretrig_i    (pretrig_i),
    .state_o      (state_o),
    .triggered_o  (triggered_o),
    .done_o       (done_o),
    .trig_addr_o  (trig_addr_o),
    .rd_en_i      (rd_en_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] smp [256];
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit mt(int i, int mask, int val);
    return ((int'(smp[i]) ^ val) & mask) == 0;
  endfunction

  function automatic int find_trig(int pt, int mode,
                                   int mask, int val);
    for (int i = pt; i < 256; i++) begin
      bit m;
      bit md;
      m  = mt(i, mask, val);
      md = (i > 0) ? mt(i - 1, mask, val) : 1'b0;
      case (mode)
        0: if (m) return i;
        1: if (m && !md) return i;
        2: if (!m && md) return i;
        default: return i;
      endcase
    end
    return -1;
  endfunction

  task automatic arm(input int pre, input int mode,
                     input int mask, input int val);
    pretrig_i    = (AW+1)'(pre);
    trig_mode_i  = 2'(mode);
    trig_mask_i  = DW'(mask);
    trig_value_i = DW'(val);
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  task automatic read_all(input int t, input int pt);
    logic [DW-1:0] e;
    for (int j = 0; j < DEPTH; j++) begin
      rd_en_i   = 1'b1;
      rd_addr_i = AW'(j);
      exp_q.push_back(smp[t - pt + j]);
      tick();
      if (rd_valid_o) begin
        e = exp_q.pop_front();
        chk($sformatf("rd_data[%0d]", j), rd_data_o, e);
      end else begin
        chk("rd_valid", rd_valid_o, 1);
      end
    end
    rd_en_i = 1'b0;
    tick();
    chk("rd_valid_pulse", rd_valid_o, 0);
    chk("sb_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic capture(input int pre, input int mode,
                         input int mask, input int val,
                         output int t);
    int pt;
    int last;
    bit seen;
    pt = (pre > DEPTH - 1) ? DEPTH - 1 : pre;
    t = find_trig(pt, mode, mask, val);
    last = t + DEPTH - 1 - pt;
    seen = 1'b0;
    arm(pre, mode, mask, val);
    for (int i = 0; i < 220; i++) begin
      probe_i = smp[i];
      tick();
      if (i == t - 1) chk("trig_early", triggered_o, 0);
      if (i == t) begin
        chk("trig_rise", triggered_o, 1);
        chk("trig_addr", trig_addr_o, t % DEPTH);
      end
      if (i == last - 1) chk("done_early", done_o, 0);
      if (i == last) begin
        chk("done_rise", done_o, 1);
        chk("done_state", state_o, 0);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("capture_timeout", 0, 1);
    read_all(t, pt);
  endtask

  task automatic fill_count();
    for (int i = 0; i < 256; i++) smp[i] = DW'(i);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    probe_i = '0;
    arm_i = 1'b0;
    abort_i = 1'b0;
    trig_mode_i = '0;
    trig_mask_i = '0;
    trig_value_i = '0;
    pretrig_i = '0;
    rd_en_i = 1'b0;
    rd_addr_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_trig", triggered_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_taddr", trig_addr_o, 0);
    chk("rst_rdata", rd_data_o, 0);
    chk("rst_rvalid", rd_valid_o, 0);
    rst_n = 1'b1;
    tick();

    // level match on a counter
    fill_count();
    capture(4, 0, 'hff, 'h2a, t);
    chk("s1_tidx", t, 42);
    chk("s1_taddr", trig_addr_o, 10);

    // rising edge on bit 0
    for (int i = 0; i < 256; i++) begin
      smp[i] = DW'((i << 1) & 'hfe);
      if (i < 8 || i >= 10) smp[i][0] = 1'b1;
    end
    capture(4, 1, 'h01, 'h01, t);
    chk("s2_tidx", t, 10);

    // clamped pre-trigger, immediate mode
    for (int i = 0; i < 256; i++) smp[i] = DW'(i * 3 + 5);
    capture(31, 3, 0, 0, t);
    chk("s3_tidx", t, 15);

    // immediate mode after pre window
    for (int i = 0; i < 256; i++) smp[i] = DW'(i * 11 + 1);
    capture(4, 3, 0, 0, t);
    chk("s4_taddr", trig_addr_o, 4);

    // abort during POST
    for (int i = 0; i < 256; i++) smp[i] = DW'(i * 7);
    arm(4, 3, 0, 0);
    for (int i = 0; i < 7; i++) begin
      probe_i = smp[i];
      tick();
    end
    chk("s5_post", state_o, 3);
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    chk("s5_rearm_ign", state_o, 3);
    chk("s5_rearm_taddr", trig_addr_o, 4);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("s5_abort_state", state_o, 0);
    chk("s5_abort_done", done_o, 0);
    chk("s5_abort_trig", triggered_o, 1);
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    chk("s5_rd_ign", rd_valid_o, 0);
    arm_i = 1'b1;
    abort_i = 1'b1;
    tick();
    arm_i = 1'b0;
    abort_i = 1'b0;
    chk("s5_arm_abort", state_o, 0);
    tick();
    chk("s5_still_idle", state_o, 0);
    capture(4, 3, 0, 0, t);

    // async reset mid-WAIT
    fill_count();
    arm(4, 0, 'hff, 'h2a);
    for (int i = 0; i < 10; i++) begin
      probe_i = smp[i];
      tick();
    end
    chk("s6_wait", state_o, 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("s6_state", state_o, 0);
    chk("s6_trig", triggered_o, 0);
    chk("s6_done", done_o, 0);
    chk("s6_taddr", trig_addr_o, 0);
    chk("s6_rdata", rd_data_o, 0);
    chk("s6_rvalid", rd_valid_o, 0);
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    tick();
    capture(4, 0, 'hff, 'h2a, t);
    chk("s6_taddr_after", trig_addr_o, 10);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/la_capture_core.md
# la_capture_core

Parametrised on-chip logic-analyzer capture engine for probing internal buses such as the SPI receive FIFO read data and flags.
- Records a `probe_i` vector into a circular sample RAM.
- Supports a configurable pre-trigger depth and four trigger modes with mask/value matching.
- Freezes the RAM once the post-trigger window is full, then serves trigger-aligned readout to the debug/host interface logic.
- Sits in the `sys_clk` domain between the probed logic and the debug transport.

## Interface
Parameters:
- `DATA_W`, 10, probe vector width (bits).
- `ADDR_W`, 9, sample RAM address width; DEPTH = 2^ADDR_W samples.

Ports (one clock; reset is asynchronous and active-low):
- `sys_clk`  in  1  capture/readout clock.
- `sys_rst_n`  in  1  asynchronous active-low reset.
- `probe_i`  in  DATA_W  signals sampled every cycle while capturing.
- `arm_i`  in  1  single-cycle pulse that starts a capture.
- `abort_i`  in  1  single-cycle pulse that cancels a capture.
- `trig_mode_i`  in  2  trigger mode: 00 level match, 01 match rising, 10 match falling, 11 immediate.
- `trig_mask_i`  in  DATA_W  bits taking part in the match.
- `trig_value_i`  in  DATA_W  compare value.
- `pretrig_i`  in  ADDR_W+1  number of samples kept before the trigger sample.
- `state_o`  out  2  current state: 0 IDLE, 1 PRE, 2 WAIT, 3 POST (DONE reported as `done_o` with `state_o`=0).
- `triggered_o`  out  1  trigger seen in the current/last capture.
- `done_o`  out  1  capture complete, RAM frozen.
- `trig_addr_o`  out  ADDR_W  physical RAM address of the trigger sample.
- `rd_en_i`  in  1  readout request.
- `rd_addr_i`  in  ADDR_W  logical index; 0 = oldest sample.
- `rd_data_o`  out  DATA_W  readout data.
- `rd_valid_o`  out  1  qualifies `rd_data_o`.

## Operation
- **Match condition:** `match = ((probe_i ^ trig_value_i) & trig_mask_i) == 0`.
  - `match_d` is `match` registered every cycle in every state; its reset value is 0.
- **Trigger per mode:**
  - 00: `match`.
  - 01: `match & ~match_d`.
  - 10: `~match & match_d`.
  - 11: constant 1.
- **Latched at arm:** the mode, mask, value and `pretrig_i` are all latched when `arm_i` is accepted.
  - The latched pre-trigger count `pt` is `min(pretrig_i, DEPTH-1)`.
- **Arm acceptance:** `arm_i` is accepted only in IDLE or DONE. On acceptance:
  - `wr_ptr`, `pre_cnt` and `triggered_o` are cleared to 0.
  - `done_o` is cleared.
  - Next state is PRE, or WAIT if `pt`=0.
- **PRE:**
  - Writes `probe_i` to RAM[`wr_ptr`] and increments `wr_ptr` (modulo DEPTH) every cycle.
  - Increments `pre_cnt`.
  - Goes to WAIT on the cycle that writes sample number `pt` (`pre_cnt`==`pt`-1).
  - The trigger is ignored in PRE.
- **WAIT:**
  - Writes every cycle, wrapping freely.
  - The first cycle with the trigger true stores that sample as the trigger sample.
  - On that cycle: `trig_addr_o`<=`wr_ptr`, `triggered_o`<=1, `post_cnt`<=DEPTH-1-`pt`.
  - Goes to POST, or straight to DONE if `post_cnt` would be 0.
- **POST:**
  - Writes every cycle and decrements `post_cnt`.
  - On the cycle that writes the last sample (`post_cnt`==1), goes to DONE.
- **DONE:**
  - No writes; `done_o`=1.
  - The RAM holds exactly DEPTH samples, with the trigger at logical index `pt`.
- **Readout:**
  - Physical address = `trig_addr_o` - `pt` + `rd_addr_i`, modulo DEPTH (ADDR_W-bit wrap arithmetic).
  - Readout is accepted only in DONE. Otherwise `rd_en_i` is ignored and `rd_valid_o` stays 0.
- **Abort:**
  - `abort_i` in any state goes to IDLE next cycle and clears `done_o`.
  - `triggered_o` keeps its value.
  - `abort_i` and `arm_i` in the same cycle: abort wins.
- **Re-arm:** `arm_i` while in PRE, WAIT or POST is ignored.
- **Storage:** inferred simple dual-port RAM with synchronous read.

## Timing
- **Reset values:** `state_o`=0, `triggered_o`=0, `done_o`=0, `trig_addr_o`=0, `rd_data_o`=0, `rd_valid_o`=0.
  - Internal pointers, counters and `match_d` are 0.
  - RAM contents are undefined.
- **Arm to first write:** `arm_i` sampled at edge k means the first sample is `probe_i` at edge k+1, written to address 0.
- **Trigger and done:**
  - `triggered_o` rises at the edge that writes the trigger sample.
  - `done_o` rises at the edge that writes sample DEPTH (the last one).
  - Total capture length after arm is DEPTH cycles plus the WAIT duration.
- **Readout latency:**
  - `rd_en_i` at edge n gives `rd_data_o` and `rd_valid_o` at edge n+1.
  - Back-to-back reads run at one per cycle.
  - `rd_valid_o` is a 1-cycle pulse per request.
- **Mid-capture reset:** `sys_rst_n` low mid-capture returns every output to its reset value immediately (asynchronous assertion). Deassertion is taken synchronously to `sys_clk`.

## Test plan
1. DATA_W=8, ADDR_W=4, `pt`=4, mode 00, mask 0xFF, value 0x2A; `probe_i` = counter starting at 0 on the first sample.
   - Trigger at sample 0x2A: `trig_addr_o`=10, `triggered_o` rises, `done_o` rises 11 cycles later.
   - Reads of index 0..15 return 0x26..0x35.
2. Mode 01, mask 0x01, value 0x01, `probe_i`[0] high at arm for 8 cycles then low 2, then high.
   - No trigger during the initial high.
   - Trigger sample is the first high after the low period.
3. `pretrig_i`=31 with ADDR_W=4, so `pt`=15; mode 11.
   - Trigger is the 16th sample, and `done_o` rises on that same edge (no POST).
   - Index 15 returns the trigger sample.
4. Mode 11, `pt`=4.
   - Trigger ignored during PRE.
   - Trigger sample is sample 5 (addr 4); index 4 equals `probe_i` at edge k+5.
5. `abort_i` during POST: next cycle `state_o`=0, `done_o`=0; `rd_en_i` gives `rd_valid_o`=0.
   - `arm_i` together with `abort_i` stays IDLE.
   - `arm_i` alone restarts with `wr_ptr` at 0.
6. Assert `sys_rst_n` low mid-WAIT, asynchronously to `sys_clk`.
   - All outputs are at reset values before the next edge.
   - After release, `arm_i` starts a normal capture and gives the same result as scenario 1.
